// File: rtl/cpu_clk_ctrl_pkg.sv
// Shared types and helpers for the CPU run-control / debug-display block.
package cpu_clk_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_HALT = 2'b00,
    MODE_RUN  = 2'b01,
    MODE_STEP = 2'b10,
    MODE_FAST = 2'b11
  } mode_e;

  // Number of LED pages needed to show the whole debug word.
  function automatic int num_pages(input int debug_width, input int led_width);
    return (debug_width + led_width - 1) / led_width;
  endfunction

  // Width of the page index; never narrower than one bit.
  function automatic int page_bits(input int pages);
    return (pages > 1) ? $clog2(pages) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer, optional debounce filter
// (CPU_CLK_CTRL_DEBOUNCE_EN) and a registered one-cycle rising-edge pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 270000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  logic sync1, sync2;
  logic level;
  logic level_q;

  if (DEBOUNCE_CYCLES < 1) begin : g_cfg_check
    $error("DEBOUNCE_CYCLES must be at least 1");
  end

  // Reset to the "pressed" level so a button held through reset produces
  // no edge until it has been released and pressed again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

`ifdef CPU_CLK_CTRL_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= 1'b1;
      cnt   <= '0;
    end else if (sync2 == level) begin
      cnt <= '0;
    end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      level <= sync2;
      cnt   <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  assign level = sync2;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= 1'b1;
      pulse   <= 1'b0;
    end else begin
      level_q <= level;
      pulse   <= level & ~level_q;
    end
  end

endmodule

// File: rtl/cpu_clk_ctrl.sv
// CPU clock-enable generator (halt/run/step/fast), tick counter and paged
// LED debug display. Debounce build option: CPU_CLK_CTRL_DEBOUNCE_EN.
module cpu_clk_ctrl
  import cpu_clk_ctrl_pkg::*;
#(
  parameter int DIV_WIDTH       = 26,
  parameter int DEFAULT_DIV     = 27000000,
  parameter int DEBUG_WIDTH     = 32,
  parameter int LED_WIDTH       = 6,
  parameter int DEBOUNCE_CYCLES = 270000,
  localparam int NUM_PAGES      = num_pages(DEBUG_WIDTH, LED_WIDTH),
  localparam int PAGE_W         = page_bits(NUM_PAGES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             mode,
  input  logic                   div_load,
  input  logic [DIV_WIDTH-1:0]   div_value,
  input  logic                   step_btn,
  input  logic                   page_btn,
  input  logic [DEBUG_WIDTH-1:0] debug,
  output logic                   cpu_en,
  output logic [31:0]            tick_count,
  output logic [PAGE_W-1:0]      page,
  output logic [LED_WIDTH-1:0]   led
);

  localparam int PAD_W = NUM_PAGES * LED_WIDTH;

  mode_e                 mode_s;
  logic [DIV_WIDTH-1:0]  div_q, cnt_q, eff_div;
  logic                  terminal;
  logic                  step_pulse, page_pulse;
  logic                  en;
  logic [PAD_W-1:0]      padded;
  logic [LED_WIDTH-1:0]  slice;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_btn (
    .clk   (clk),
    .rst   (rst),
    .btn   (step_btn),
    .pulse (step_pulse)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_page_btn (
    .clk   (clk),
    .rst   (rst),
    .btn   (page_btn),
    .pulse (page_pulse)
  );

  assign mode_s   = mode_e'(mode);
  assign eff_div  = (div_q == '0) ? DIV_WIDTH'(1) : div_q;
  assign terminal = (cnt_q >= eff_div - DIV_WIDTH'(1));

  // A divisor load on the terminal cycle restarts the period without a pulse.
  always_comb begin
    en = 1'b0;
    case (mode_s)
      MODE_RUN:  en = terminal & ~div_load;
      MODE_STEP: en = step_pulse;
      MODE_FAST: en = 1'b1;
      default:   en = 1'b0;
    endcase
  end

  assign cpu_en = en & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= DIV_WIDTH'(DEFAULT_DIV);
      cnt_q <= '0;
    end else if (div_load) begin
      div_q <= div_value;
      cnt_q <= '0;
    end else begin
      case (mode_s)
        MODE_RUN:  cnt_q <= terminal ? '0 : cnt_q + 1'b1;
        MODE_STEP: cnt_q <= '0;
        MODE_FAST: cnt_q <= '0;
        default:   cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tick_count <= '0;
    else if (en) tick_count <= tick_count + 32'd1;
  end

  // Bits beyond the debug word read as zero on the last page.
  always_comb begin
    padded = '0;
    padded[DEBUG_WIDTH-1:0] = debug;
  end

  always_comb begin
    slice = '0;
    for (int p = 0; p < NUM_PAGES; p++) begin
      if (page == PAGE_W'(p)) slice = padded[p*LED_WIDTH +: LED_WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      page <= '0;
      led  <= '1;
    end else begin
      led <= ~slice;
      if (page_pulse) page <= (page == PAGE_W'(NUM_PAGES - 1)) ? '0 : page + 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Bench for cpu_clk_ctrl: vector table, directed corner sequences and a
// randomized phase checked every cycle against a behavioural model.
module tb_cpu_clk_ctrl;
  import cpu_clk_ctrl_pkg::*;

  localparam int DW      = 26;
  localparam int DEF_DIV = 4;
  localparam int DBG_W   = 32;
  localparam int LED_W   = 6;
  localparam int DEB     = 8;
  localparam int NP      = 6;
`ifdef CPU_CLK_CTRL_DEBOUNCE_EN
  localparam bit DEB_ON   = 1'b1;
  localparam int STEP_LAT = 3 + DEB;
  localparam int RISE_LAT = 4;
`else
  localparam bit DEB_ON   = 1'b0;
  localparam int STEP_LAT = 3;
  localparam int RISE_LAT = 3;
`endif

  logic             clk = 1'b0;
  logic             rst, div_load, step_btn, page_btn;
  logic [1:0]       mode;
  logic [DW-1:0]    div_value;
  logic [DBG_W-1:0] debug;
  logic             cpu_en;
  logic [31:0]      tick_count;
  logic [2:0]       page;
  logic [LED_W-1:0] led;

  always #5 clk = ~clk;

  cpu_clk_ctrl #(
    .DIV_WIDTH(DW), .DEFAULT_DIV(DEF_DIV), .DEBUG_WIDTH(DBG_W),
    .LED_WIDTH(LED_W), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .div_load(div_load),
    .div_value(div_value), .step_btn(step_btn), .page_btn(page_btn),
    .debug(debug), .cpu_en(cpu_en), .tick_count(tick_count),
    .page(page), .led(led)
  );

  typedef struct {
    logic [1:0] mode;
    bit         exp_en;
    int         exp_tick;
  } vec_t;

  // stimulus shadows, copied onto the DUT inputs at each falling edge
  bit          s_rst, s_load, s_step, s_pg;
  logic [1:0]  s_mode;
  int          s_dv;
  logic [31:0] s_dbg;

  // reference model
  int          m_div, m_cnt, m_page;
  logic [31:0] m_ticks;
  logic [5:0]  m_led;
  bit          b_lvl[2];
  int          b_run[2];
  int          step_q[$];
  int          page_q[$];
  int          e;

  int n_chk, n_pass;
  bit last_en;
  int en_cnt, last_en_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, e);
  endtask

  task automatic model_reset();
    m_div = DEF_DIV; m_cnt = 0; m_ticks = '0; m_page = 0; m_led = '1;
    b_lvl = '{1'b1, 1'b1}; b_run = '{0, 0};
    step_q.delete(); page_q.delete();
  endtask

  // Debounced level flips after DEB consecutive samples that differ from it.
  task automatic btn_model(input int i, input bit raw, output bit rose);
    rose = 1'b0;
    if (DEB_ON) begin
      if (raw != b_lvl[i]) begin
        b_run[i]++;
        if (b_run[i] == DEB) begin
          b_lvl[i] = raw; b_run[i] = 0; rose = raw;
        end
      end else b_run[i] = 0;
    end else begin
      rose = raw & ~b_lvl[i];
      b_lvl[i] = raw;
    end
  endtask

  task automatic cycle();
    bit step_due, page_due, exp_en, rose;
    int eff, idx;
    @(negedge clk);
    rst = s_rst; mode = s_mode; div_load = s_load; div_value = DW'(s_dv);
    step_btn = s_step; page_btn = s_pg; debug = s_dbg;
    #2;
    step_due = 1'b0; page_due = 1'b0; eff = 1; exp_en = 1'b0;
    if (s_rst) model_reset();
    else begin
      if (step_q.size() > 0 && step_q[0] == e) begin step_due = 1'b1; void'(step_q.pop_front()); end
      if (page_q.size() > 0 && page_q[0] == e) begin page_due = 1'b1; void'(page_q.pop_front()); end
      eff = (m_div == 0) ? 1 : m_div;
      case (s_mode)
        MODE_RUN:  exp_en = (m_cnt == eff - 1) && !s_load;
        MODE_STEP: exp_en = step_due;
        MODE_FAST: exp_en = 1'b1;
        default:   exp_en = 1'b0;
      endcase
    end
    chk("cpu_en", cpu_en, exp_en);
    chk("tick_count", tick_count, m_ticks);
    chk("page", page, m_page);
    chk("led", led, m_led);
    last_en = cpu_en;
    if (cpu_en) begin en_cnt++; last_en_e = e; end
    if (!s_rst) begin
      m_ticks += 32'(exp_en);
      if (s_load) begin m_div = s_dv; m_cnt = 0; end
      else if (s_mode == MODE_RUN) m_cnt = (m_cnt == eff - 1) ? 0 : m_cnt + 1;
      else if (s_mode != MODE_HALT) m_cnt = 0;
      for (int b = 0; b < LED_W; b++) begin
        idx = m_page * LED_W + b;
        m_led[b] = ~((idx < DBG_W) ? s_dbg[idx] : 1'b0);
      end
      if (page_due) m_page = (m_page + 1) % NP;
      btn_model(0, s_step, rose);
      if (rose) step_q.push_back(e + RISE_LAT);
      btn_model(1, s_pg, rose);
      if (rose) page_q.push_back(e + RISE_LAT);
    end
    e++;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  vec_t       vt[20];
  logic [5:0] led_tab[NP];
  int         bounce[5];

  initial begin
    int en0, t_stable, step_hold, pg_hold;
    n_chk = 0; n_pass = 0; en_cnt = 0; last_en_e = 0; e = 0;
    for (int k = 1; k <= 20; k++) vt[k-1] = '{MODE_RUN, (k % 4 == 0), (k - 1) / 4};
    for (int p = 0; p < NP; p++) led_tab[p] = 6'b000000;
    led_tab[5] = 6'b111100;
    bounce = '{1, 0, 1, 1, 0};
    s_rst = 1'b1; s_mode = MODE_RUN; s_load = 1'b0; s_dv = 0;
    s_step = 1'b0; s_pg = 1'b0; s_dbg = '0;
    model_reset();
    run(2);

    // 1: RUN from reset with the default divisor
    s_rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      s_mode = vt[i].mode;
      cycle();
      chk("t1_en", last_en, vt[i].exp_en);
      chk("t1_tick", tick_count, vt[i].exp_tick);
    end
    s_mode = MODE_HALT;
    cycle();
    chk("t1_total", tick_count, 5);

    // 2: divisor 0 runs every cycle; load on a terminal cycle suppresses the pulse
    s_mode = MODE_RUN; s_load = 1'b1; s_dv = 0;
    cycle();
    s_load = 1'b0; en0 = en_cnt;
    run(5);
    chk("div0_every_cycle", en_cnt - en0, 5);
    s_load = 1'b1; s_dv = 3;
    cycle();
    chk("load_on_tc_no_pulse", last_en, 0);
    s_load = 1'b0; en0 = en_cnt;
    run(2);
    chk("after_load_quiet", en_cnt - en0, 0);
    cycle();
    chk("after_load_pulse", last_en, 1);

    // 3: bouncy then stable step press; presses in HALT are dropped
    s_mode = MODE_STEP;
    run(3);
    en0 = en_cnt;
    for (int i = 0; i < 5; i++) begin s_step = bounce[i][0]; cycle(); end
    s_step = 1'b1; t_stable = e;
    run(20);
    s_step = 1'b0;
    run(20);
    chk("step_count", en_cnt - en0, DEB_ON ? 1 : 3);
    chk("step_latency", last_en_e - t_stable, STEP_LAT);
    s_mode = MODE_HALT; en0 = en_cnt;
    repeat (2) begin
      s_step = 1'b1; run(12);
      s_step = 1'b0; run(12);
    end
    s_mode = MODE_STEP;
    run(15);
    chk("halt_step_dropped", en_cnt - en0, 0);

    // 4: page stepping over an all-ones debug word
    s_mode = MODE_HALT; s_dbg = '1;
    run(2);
    for (int i = 0; i < NP; i++) begin
      s_pg = 1'b1; run(12);
      s_pg = 1'b0; run(14);
      chk("page_step", page, (i + 1) % NP);
      chk("page_led", led, led_tab[(i + 1) % NP]);
    end

    // 5: FAST then HALT, then RUN resumes from the held count
    s_rst = 1'b1; run(2);
    s_rst = 1'b0; s_mode = MODE_FAST;
    run(10);
    s_mode = MODE_HALT;
    cycle();
    chk("fast_ticks", tick_count, 10);
    run(5);
    chk("halt_hold", tick_count, 10);
    s_mode = MODE_RUN; run(2);
    s_mode = MODE_HALT; run(5);
    s_mode = MODE_RUN;
    cycle();
    chk("resume_no_pulse", last_en, 0);
    cycle();
    chk("resume_pulse", last_en, 1);
    chk("resume_ticks", tick_count, 10);

    // 6: reset mid-count with the step button held
    run(2);
    s_step = 1'b1;
    run(2);
    s_rst = 1'b1;
    cycle();
    chk("rst_tick", tick_count, 0);
    chk("rst_led", led, 6'h3f);
    run(2);
    s_rst = 1'b0; s_mode = MODE_STEP; en0 = en_cnt;
    run(20);
    chk("held_through_rst", en_cnt - en0, 0);
    s_step = 1'b0; run(15);
    s_step = 1'b1; run(20);
    s_step = 1'b0; run(15);
    chk("repress_pulse", en_cnt - en0, 1);

    // randomized phase
    step_hold = 0; pg_hold = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) s_mode = 2'($urandom_range(0, 3));
      s_load = ($urandom_range(0, 15) == 0);
      s_dv   = $urandom_range(0, 6);
      s_dbg  = $urandom;
      if (step_hold == 0) begin s_step = ~s_step; step_hold = $urandom_range(1, 14); end
      step_hold--;
      if (pg_hold == 0) begin s_pg = ~s_pg; pg_hold = $urandom_range(1, 14); end
      pg_hold--;
      s_rst = ($urandom_range(0, 199) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cpu_clk_ctrl.md
# cpu_clk_ctrl

Run-control and debug-display block between the board oscillator and the CPU core. Divides `clk` into a one-cycle CPU clock-enable pulse with halt, free-run, fast-run and single-step modes, all in the `clk` domain with no derived clocks. Adds a reprogrammable divisor and a retired-tick counter. Shows the CPU debug word on the board LEDs one page at a time, with a button to step through the pages.

## Interface
- `DIV_WIDTH`, 26: width of the divisor and of the divider counter.
- `DEFAULT_DIV`, 27000000: divisor value loaded at reset.
- `DEBUG_WIDTH`, 32: width of the debug word.
- `LED_WIDTH`, 6: number of LEDs.
- `DEBOUNCE_CYCLES`, 270000: number of stable samples a button needs before it is accepted.

Ports (clock and reset first):
- `clk`  in  1  system clock; the only clock in the block.
- `rst`  in  1  reset, asynchronous, active-high.
- `mode`  in  2  run mode: 00 HALT, 01 RUN, 10 STEP, 11 FAST.
- `div_load`  in  1  one-cycle strobe that loads `div_value`.
- `div_value`  in  DIV_WIDTH  new divisor value.
- `step_btn`  in  1  raw single-step button, active-high, asynchronous.
- `page_btn`  in  1  raw LED-page button, active-high, asynchronous.
- `debug`  in  DEBUG_WIDTH  debug word from the CPU.
- `cpu_en`  out  1  CPU clock enable, a one-cycle pulse.
- `tick_count`  out  32  count of `cpu_en` pulses.
- `page`  out  $clog2(NUM_PAGES)  currently displayed page.
- `led`  out  LED_WIDTH  LED drive, active-low.

## Operation
- NUM_PAGES = ceil(DEBUG_WIDTH/LED_WIDTH); with the defaults this is 6. Page p displays `debug[p*LED_WIDTH +: LED_WIDTH]`. Bits at or above DEBUG_WIDTH read as 0.
- Effective divisor = max(divisor register, 1).
- HALT: the divider counter holds its value and `cpu_en` stays 0.
- RUN:
  - counter runs 0..div-1;
  - `cpu_en` = 1 in the cycle where counter == div-1;
  - counter then wraps to 0.
- FAST: `cpu_en` = 1 every cycle and the counter is held at 0.
- STEP:
  - counter is held at 0;
  - each accepted step-button rising edge produces exactly one `cpu_en` pulse;
  - step presses in any other mode are dropped, never queued.
- Mode is sampled every cycle; a change applies to `cpu_en` in the same cycle it is seen.
- `div_load`: divisor ← `div_value` and counter ← 0 on the next edge.
- `div_load` coinciding with a terminal count: the load wins and no pulse is produced in that cycle.
- `tick_count` increments on every `cpu_en` and wraps from 2^32-1 to 0.
- Accepted page-button rising edge: `page` increments, wrapping NUM_PAGES-1 → 0.
- `led` is registered: `led` ← ~slice(page) on every cycle.
- Reset values:
  - `cpu_en` = 0, `tick_count` = 0, `page` = 0;
  - `led` = all ones (LEDs off);
  - divisor = DEFAULT_DIV, counter = 0;
  - debounce state cleared.
- Reset mid-operation: everything returns to the reset values immediately. A button held through reset must be released and pressed again before it is accepted.

## Timing
- Button path: 2-flop synchronizer → debounce → rising-edge pulse.
- Step latency: a press stable from edge t gives a `cpu_en` pulse at edge t+3+DEBOUNCE_CYCLES, or t+3 without debounce.
- RUN with div = N: first pulse N cycles after reset release or after a load; period N thereafter.
- `led` lags `debug` and `page` by 1 cycle.
- A page change is visible on `led` 1 cycle after `page` updates.

## Configuration
- `CPU_CLK_CTRL_DEBOUNCE_EN` defined:
  - each button needs DEBOUNCE_CYCLES consecutive equal synchronized samples before its level changes;
  - bounces shorter than that are ignored.
- Undefined: the synchronizer output feeds the edge detector directly and no debounce counter is built.

## Structure
- Package `cpu_clk_ctrl_pkg` holds:
  - the mode enum (MODE_HALT, MODE_RUN, MODE_STEP, MODE_FAST);
  - a NUM_PAGES helper function.
- Sub-module `btn_debounce`: synchronizer, optional debounce counter and rising-edge pulse output. It is instantiated twice, once per button.
- Top level holds the divider, mode logic, tick counter, page register and LED register.

## Test plan
Bench overrides: DEFAULT_DIV=4, DEBOUNCE_CYCLES=8, DEBUG_WIDTH=32, LED_WIDTH=6.
1. Reset, then RUN for 20 cycles → `cpu_en` pulses at cycles 4, 8, 12, 16, 20; `tick_count` = 5.
2. `div_load` with 0 while in RUN → `cpu_en` every cycle. `div_load` with 3 issued on a terminal-count cycle → no pulse in that cycle; next pulse 3 cycles later.
3. STEP mode:
   - a 5-cycle bouncy press followed by a stable 20-cycle press → exactly one pulse, at stable start +11;
   - presses made in HALT → no pulses.
4. `debug` = 32'hFFFF_FFFF:
   - 5 page presses → `page` reaches 5 and `led` = 6'b111100 (only bits 30 and 31 exist);
   - 6th press → `page` = 0.
5. FAST for 10 cycles, then HALT → `tick_count` = 10 and holds. Switch to RUN → counter resumes from its held value.
6. Assert `rst` mid-count while `step_btn` is held → outputs return to reset values at once; no step pulse until the button is released and pressed again.
